uart_rx: RTL and testbench

Serial-to-parallel UART receiver, 8N1, LSB first; the receive-side counterpart of Uart_tx. It sits between the FPGA serial input pin and the image-data byte sink. The incoming line is synchronized, each start bit is validated at its midpoint, and 8 data bits plus the stop bit are sampled at bit centres. Each byte is delivered with a one-cycle valid strobe, and framing errors are flagged.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to the transmitter and
// receiver, frame geometry and the default bit period.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 87;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_CLEANUP = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    START   = ST_START,
    DATA    = ST_DATA,
    STOP    = ST_STOP,
    CLEANUP = ST_CLEANUP
  } uart_state_e;

  // Count at which the start bit is re-checked: the middle of the bit.
  function automatic int halfBitCount(input int clksPerBit);
    return (clksPerBit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input pin; the reset value is
// chosen to match the pin's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: validates the start bit at its midpoint,
// samples data and stop bits at their centres and strobes out each byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(halfBitCount(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic rxSync;

  uart_state_e          state_q,  state_d;
  logic [CNT_W-1:0]     clkCnt_q, clkCnt_d;
  logic [2:0]           bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [DATA_BITS-1:0] byte_q,   byte_d;
  logic                 dv_q,     dv_d;
  logic                 ferr_q,   ferr_d;
  logic                 active_q, active_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rxSync (
    .clk_i  (i_Clock),
    .rst_ni (i_Reset_n),
    .d_i    (i_Rx_Serial),
    .q_o    (rxSync)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      clkCnt_q <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      clkCnt_q <= clkCnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  // Strobes default low so each lasts exactly the cycle after the stop sample.
  always_comb begin
    state_d  = state_q;
    clkCnt_d = clkCnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;

    case (state_q)
      IDLE: begin
        clkCnt_d = '0;
        bitIdx_d = '0;
        if (!rxSync) begin
          state_d = START;
        end
      end

      START: begin
        if (clkCnt_q == HALF_CNT) begin
          clkCnt_d = '0;
          if (!rxSync) begin
            active_d = 1'b1;
            state_d  = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clkCnt_d = clkCnt_q + 1'b1;
        end
      end

      DATA: begin
        if (clkCnt_q == LAST_CNT) begin
          clkCnt_d = '0;
          shift_d  = {rxSync, shift_q[DATA_BITS-1:1]};
          if (bitIdx_q == LAST_BIT) begin
            bitIdx_d = '0;
            state_d  = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end else begin
          clkCnt_d = clkCnt_q + 1'b1;
        end
      end

      // A low stop bit discards the byte so the held output stays trustworthy.
      STOP: begin
        if (clkCnt_q == LAST_CNT) begin
          clkCnt_d = '0;
          if (rxSync) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = CLEANUP;
        end else begin
          clkCnt_d = clkCnt_q + 1'b1;
        end
      end

      CLEANUP: begin
        active_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_Rx_DV        = dv_q;
  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Frame_Err = ferr_q;
  assign o_Rx_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level serializer drives the line
// and a queue of expected bytes/framing errors is matched against the strobes.
module tb_uart_rx;

  localparam int CLKS        = 8;
  localparam int DV_LATENCY  = 2 + (CLKS - 1) / 2 + 1 + 9 * CLKS + 1;

  logic       clock = 1'b0;
  logic       resetN;
  logic       rxSerial;
  logic       rxDv;
  logic [7:0] rxByte;
  logic       rxFrameErr;
  logic       rxActive;

  uart_rx #(
    .CLKS_PER_BIT (CLKS)
  ) dut (
    .i_Clock        (clock),
    .i_Reset_n      (resetN),
    .i_Rx_Serial    (rxSerial),
    .o_Rx_DV        (rxDv),
    .o_Rx_Byte      (rxByte),
    .o_Rx_Frame_Err (rxFrameErr),
    .o_Rx_Active    (rxActive)
  );

  always #5 clock = ~clock;

  int cycleCnt = 0;
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  typedef struct {
    logic       isErr;
    logic [7:0] data;
  } expT;

  typedef struct {
    logic [7:0] data;
    logic       stopGood;
    int         gap;
    logic       expErr;
    logic [7:0] expByte;
  } vecT;

  expT        expQ[$];
  vecT        vecs[5];
  int         checks = 0;
  int         errors = 0;
  int         dvCount = 0;
  int         errCount = 0;
  int         activeCycles = 0;
  int         lastDvCycle = -1;
  int         lastStartCycle = 0;
  logic [7:0] lastByte = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectEvent(input logic isErr, input logic [7:0] data);
    expT e;
    e.isErr = isErr;
    e.data  = data;
    expQ.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    rxSerial = 1'b1;
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic driveBit(input logic val);
    rxSerial = val;
    repeat (CLKS) @(posedge clock);
    #2;
  endtask

  // Drives one 8N1 frame starting on the current aligned slot.
  task automatic applyStimulus(input logic [7:0] data, input logic stopGood,
                               input int gap);
    lastStartCycle = cycleCnt;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stopGood);
    idleCycles(gap);
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 20 * CLKS;
    while (expQ.size() != 0 && budget > 0) begin
      @(posedge clock);
      budget--;
    end
    #2;
    checkOutput(name, expQ.size(), 0);
  endtask

  // Strobe monitor: every DV/Frame_Err must match the oldest expectation.
  task automatic monitorLoop();
    logic prevStrobe;
    expT  e;
    prevStrobe = 1'b0;
    forever begin
      @(negedge clock);
      if (resetN === 1'b1) begin
        if (rxActive === 1'b1) activeCycles++;
        if (rxDv === 1'b1 || rxFrameErr === 1'b1) begin
          checkOutput("strobeExclusive", rxDv & rxFrameErr, 0);
          checkOutput("strobeSpacing", prevStrobe, 0);
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedStrobe: got dv=%b err=%b byte=%0h, expected none",
                     rxDv, rxFrameErr, rxByte);
          end else begin
            e = expQ.pop_front();
            checkOutput("strobeKind", rxFrameErr, e.isErr);
            checkOutput("rxByte", rxByte, e.data);
          end
          if (rxDv === 1'b1) begin
            dvCount++;
            lastDvCycle = cycleCnt;
          end else begin
            errCount++;
          end
        end
        prevStrobe = rxDv | rxFrameErr;
      end else begin
        prevStrobe = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a0, d0, e0;
    logic [7:0] d;
    logic       good;

    resetN   = 1'b0;
    rxSerial = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    checkOutput("resetDv", rxDv, 0);
    checkOutput("resetByte", rxByte, 0);
    checkOutput("resetErr", rxFrameErr, 0);
    checkOutput("resetActive", rxActive, 0);
    resetN = 1'b1;
    fork
      monitorLoop();
    join_none
    idleCycles(2 * CLKS);

    $display("[TB] single byte 8'h21");
    expectEvent(1'b0, 8'h21);
    applyStimulus(8'h21, 1'b1, 2 * CLKS);
    lastByte = 8'h21;
    checkOutput("dvLatency", lastDvCycle - lastStartCycle, DV_LATENCY);
    checkOutput("dvCountSingle", dvCount, 1);
    checkOutput("errCountSingle", errCount, 0);

    $display("[TB] table: back-to-back frames and bad stop bit");
    vecs[0] = '{8'h00, 1'b1, 0,        1'b0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 0,        1'b0, 8'hFF};
    vecs[2] = '{8'hA5, 1'b1, 2 * CLKS, 1'b0, 8'hA5};
    vecs[3] = '{8'h5A, 1'b0, 2 * CLKS, 1'b1, 8'hA5};
    vecs[4] = '{8'h3C, 1'b1, 2 * CLKS, 1'b0, 8'h3C};
    for (int i = 0; i < 5; i++) begin
      expectEvent(vecs[i].expErr, vecs[i].expByte);
      applyStimulus(vecs[i].data, vecs[i].stopGood, vecs[i].gap);
      if (!vecs[i].expErr) lastByte = vecs[i].expByte;
    end
    waitDrain("drainTable");
    checkOutput("dvCountTable", dvCount, 5);
    checkOutput("errCountTable", errCount, 1);

    $display("[TB] short glitch on idle line");
    a0 = activeCycles;
    d0 = dvCount;
    e0 = errCount;
    rxSerial = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    idleCycles(3 * CLKS);
    checkOutput("glitchActive", activeCycles - a0, 0);
    checkOutput("glitchDv", dvCount - d0, 0);
    checkOutput("glitchErr", errCount - e0, 0);

    $display("[TB] reset during data bit 4");
    d0 = dvCount;
    e0 = errCount;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(i[0]);
    rxSerial = 1'b1;
    repeat (CLKS / 2) @(posedge clock);
    #2;
    checkOutput("midFrameActive", rxActive, 1);
    resetN = 1'b0;
    #1;
    checkOutput("midResetDv", rxDv, 0);
    checkOutput("midResetByte", rxByte, 0);
    checkOutput("midResetErr", rxFrameErr, 0);
    checkOutput("midResetActive", rxActive, 0);
    repeat (3) @(posedge clock);
    #2;
    resetN = 1'b1;
    lastByte = 8'h00;
    idleCycles(2 * CLKS);
    expectEvent(1'b0, 8'hC3);
    applyStimulus(8'hC3, 1'b1, 2 * CLKS);
    lastByte = 8'hC3;
    waitDrain("drainReset");
    checkOutput("resetDvCount", dvCount - d0, 1);
    checkOutput("resetErrCount", errCount - e0, 0);

    $display("[TB] loopback of 256 sequential bytes");
    e0 = errCount;
    for (int i = 0; i < 256; i++) begin
      expectEvent(1'b0, 8'(i));
      lastByte = 8'(i);
      applyStimulus(8'(i), 1'b1,
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12)));
    end
    waitDrain("drainLoopback");
    checkOutput("loopbackErrCount", errCount - e0, 0);

    $display("[TB] random frames with occasional bad stop bits");
    for (int i = 0; i < 40; i++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      if (good) begin
        lastByte = d;
        expectEvent(1'b0, d);
        applyStimulus(d, 1'b1, int'($urandom_range(0, 12)));
      end else begin
        expectEvent(1'b1, lastByte);
        applyStimulus(d, 1'b0, CLKS + int'($urandom_range(0, 12)));
      end
    end
    waitDrain("drainRandom");
    checkOutput("finalByte", rxByte, lastByte);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
